// File: rtl/div_if.sv
// Issue/writeback handshake bundle for the iterative divider.
// A transfer occurs on a rising edge where valid and ready are both high; the source holds its payload stable until then.
interface div_if #(
  parameter int WORD_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_op;
  logic [WORD_WIDTH-1:0] in_dividend;
  logic [WORD_WIDTH-1:0] in_divisor;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_result;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, in_op, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU with flush and writeback back-pressure.
// Define DIV_EARLY_OUT_EN to skip leading-zero iterations of |dividend|; otherwise 32 iterations always.
module div_iter_unit #(
  parameter int WORD_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  output logic       busy,
  output logic [2:0] dbg_state,
  div_if.slave       bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CALC  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] MSB_IDX = 5'(WORD_WIDTH - 1);

  state_t                state_q, state_d;
  logic [1:0]            op_q;
  logic [WORD_WIDTH-1:0] a_q, b_q, dvd_q, rem_q, quo_q, result_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [5:0]            cnt_q;
  logic                  q_neg_q, r_neg_q;

  logic                  is_signed, is_rem, a_neg, b_neg, div_zero, overflow, special;
  logic [WORD_WIDTH-1:0] abs_a, abs_b, special_res, q_fix, r_fix;
  logic [WORD_WIDTH:0]   shifted, diff;
  logic [4:0]            loc;

  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];
  assign a_neg     = is_signed & a_q[WORD_WIDTH-1];
  assign b_neg     = is_signed & b_q[WORD_WIDTH-1];
  assign abs_a     = a_neg ? -a_q : a_q;
  assign abs_b     = b_neg ? -b_q : b_q;
  assign div_zero  = (b_q == '0);
  assign overflow  = is_signed && (a_q == {1'b1, {(WORD_WIDTH-1){1'b0}}}) && (b_q == '1);
  assign special   = div_zero | overflow;

  always_comb begin
    special_res = '0;
    if (div_zero)      special_res = is_rem ? a_q : '1;
    else if (!is_rem)  special_res = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  end

`ifdef DIV_EARLY_OUT_EN
  // Position of the leading one; zero dividend still runs one iteration.
  always_comb begin
    loc = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (abs_a[i]) loc = 5'(i);
    end
  end
`else
  assign loc = MSB_IDX;
`endif

  // Remainder stays below the divisor, so one extra bit suffices for the trial subtract.
  assign shifted = {rem_q, dvd_q[WORD_WIDTH-1]};
  assign diff    = shifted - {1'b0, b_q};
  assign q_fix   = q_neg_q ? -quo_q : quo_q;
  assign r_fix   = r_neg_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid && !flush) state_d = S_SETUP;
      S_SETUP: state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == 6'd1) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid && !flush) begin
          op_q  <= bus.in_op;
          a_q   <= bus.in_dividend;
          b_q   <= bus.in_divisor;
          tag_q <= bus.in_tag;
        end
        S_SETUP: begin
          if (special) begin
            result_q <= special_res;
          end else begin
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            b_q     <= abs_b;
            dvd_q   <= abs_a << (MSB_IDX - loc);
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= {1'b0, loc} + 6'd1;
          end
        end
        S_CALC: begin
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - 6'd1;
          if (!diff[WORD_WIDTH]) begin
            rem_q <= diff[WORD_WIDTH-1:0];
            quo_q <= {quo_q[WORD_WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted[WORD_WIDTH-1:0];
            quo_q <= {quo_q[WORD_WIDTH-2:0], 1'b0};
          end
        end
        S_FIXUP: result_q <= is_rem ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: arithmetic results, latency per build, flush, reset and back-pressure.
module tb_div_iter_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       busy;
  logic [2:0] dbg_state;
  int         vectors = 0;
  int         miscompares = 0;

  div_if #(.WORD_WIDTH(32), .TAG_WIDTH(6)) bus ();

  div_iter_unit #(.WORD_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .busy      (busy),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, expv);
    end
  endtask

  // Normal-path latency given the hand-derived iteration count n.
  function automatic int norm_lat(input int n);
`ifdef DIV_EARLY_OUT_EN
    return n + 3;
`else
    return 35;
`endif
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_tag      = tag;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int cycles;
    cycles = 1;
    while (!bus.out_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({name, " valid"}, 32'(bus.out_valid), 32'd1);
    check({name, " latency"}, 32'(cycles), 32'(exp_lat));
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag,
                        input logic [31:0] exp_res, input int exp_lat);
    issue(op, a, b, tag);
    wait_result(name, exp_lat);
    check({name, " result"}, bus.out_result, exp_res);
    check({name, " tag"}, 32'(bus.out_tag), 32'(tag));
    @(posedge clk); #1;
    check({name, " retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_op       = 2'b00;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_result", bus.out_result, 32'd0);
    check("rst out_tag", 32'(bus.out_tag), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // 100 = 0b1100100 -> loc 6, n 7
    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 6'd5, 32'd14, norm_lat(7));
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 6'd6, 32'd2, norm_lat(7));
    // |-7| = 7 -> loc 2, n 3
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 6'd7, 32'hFFFF_FFFD, norm_lat(3));
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 6'd8, 32'hFFFF_FFFF, norm_lat(3));
    run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 6'd9, 32'hFFFF_FFFD, norm_lat(3));
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 6'd10, 32'hFFFF_FFFF, 2);
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 6'd11, 32'd5, 2);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 32'h8000_0000, 2);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13, 32'd0, 2);
    run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 6'd14, 32'hFFFF_FFFF, 35);
    run_op("divu 0/9", 2'b01, 32'd0, 32'd9, 6'd15, 32'd0, norm_lat(1));
    run_op("rem -100/7", 2'b10, 32'hFFFF_FF9C, 32'd7, 6'd63, 32'hFFFF_FFFE, norm_lat(7));

    // Flush on the third CALC cycle of a long op.
    issue(2'b01, 32'hFFFF_FFFF, 32'd1, 6'd20);
    repeat (3) @(posedge clk);
    #1;
    check("pre-flush state", 32'(dbg_state), 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush in_ready", 32'(bus.in_ready), 32'd1);
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    // 9 = 0b1001 -> loc 3, n 4
    run_op("divu 9/3", 2'b01, 32'd9, 32'd3, 6'd21, 32'd3, norm_lat(4));

    // Flush in IDLE blocks a coincident request.
    flush = 1'b1;
    issue(2'b01, 32'd9, 32'd3, 6'd22);
    flush = 1'b0;
    check("idle flush busy", 32'(busy), 32'd0);

    // Back-pressure: result must hold until out_ready rises.
    bus.out_ready = 1'b0;
    issue(2'b01, 32'd100, 32'd7, 6'd33);
    wait_result("bp", norm_lat(7));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold valid", 32'(bus.out_valid), 32'd1);
      check("bp hold result", bus.out_result, 32'd14);
      check("bp hold tag", 32'(bus.out_tag), 32'd33);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp released", 32'(bus.out_valid), 32'd0);
    check("bp idle", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of an operation discards it.
    issue(2'b01, 32'hFFFF_FFFF, 32'd1, 6'd40);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst out_result", bus.out_result, 32'd0);
    check("midrst out_tag", 32'(bus.out_tag), 32'd0);
    run_op("post-rst divu 100/7", 2'b01, 32'd100, 32'd7, 6'd1, 32'd14, norm_lat(7));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring integer divider for the OoO execution cluster; implements RISC-V DIV/DIVU/REM/REMU.
- Accepts one op per issue handshake and returns a tagged result on a valid/ready writeback handshake.
- Uses the leading-one position of |dividend| to skip leading-zero iterations (early out).
- Honours pipeline flush and writeback back-pressure.

Parameters:
WORD_WIDTH, 32, operand/result width (fixed 32 for this design; 5-bit position logic).
TAG_WIDTH, 6, ROB tag width carried alongside the op.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  issue request
in_ready  output  1  unit can accept (high only in IDLE)
in_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
in_dividend  input  WORD_WIDTH  rs1
in_divisor  input  WORD_WIDTH  rs2
in_tag  input  TAG_WIDTH  ROB tag
flush  input  1  kill in-flight op
out_valid  output  1  result available
out_ready  input  1  writeback accepts
out_result  output  WORD_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
out_tag  output  TAG_WIDTH  tag of result
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, busy=0.
- Accept: in_valid & in_ready on a rising edge latches op, operands and tag, then moves to SETUP.
- SETUP (1 cycle):
  - Signed ops: abs values; record q_neg = sign(a)^sign(b), r_neg = sign(a).
  - Divisor==0: result = all-ones (quotient) or dividend (remainder); go to DONE.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: result = 0x80000000 (quotient) or 0 (remainder); go to DONE.
  - Otherwise: loc = 5-bit index of the most significant 1 of |a| (0 if |a|==0); n = loc+1.
  - Pre-shift |a| left by 31-loc. Clear partial remainder and quotient. Go to CALC.
- CALC (n cycles): per cycle, shift {rem,dividend} left 1; trial subtract divisor; if non-negative, commit and shift 1 into quotient, else shift 0. Iteration counter decrements; last iteration goes to FIXUP.
- FIXUP (1 cycle): negate quotient if q_neg (signed ops), negate remainder if r_neg; select per op; go to DONE.
- DONE: out_valid=1, out_result/out_tag stable until out_valid & out_ready, then IDLE.
- Latency, acceptance edge to first out_valid cycle:
  - Normal: n+3 cycles (1..32 iterations, so 4..35 cycles).
  - Special cases: 2 cycles.
- Back-pressure: DONE holds indefinitely; outputs must not change while out_valid & !out_ready.
- flush:
  - In any non-IDLE state, next state is IDLE and out_valid drops the next cycle (even if out_ready is also high that cycle; no result counted).
  - flush in IDLE coincident with in_valid: request is not accepted.
- rst mid-operation: returns to reset values the next edge; the partial op is discarded.
- in_ready is low in every state except IDLE; no new op is accepted in the DONE-to-IDLE transition cycle.

Optional Feature:
DIV_EARLY_OUT_EN:
- Defined: leading-one skip as above, n = loc+1.
- Undefined: no leading-one logic; n = 32 always, no pre-shift; normal latency fixed at 35 cycles.
- Results are identical in both builds.

Test Plan:
- DIVU 100/7, tag 5, out_ready=1 -> out_result=14, out_tag=5; out_valid 10 cycles after accept (loc=6); REMU same operands -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, each in 2 cycles; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF after 35 cycles; DIVU 0/9 -> 0 after 4 cycles; with DIV_EARLY_OUT_EN undefined, both take 35.
- flush asserted 3 cycles into CALC -> busy=0 and in_ready=1 next cycle, no out_valid; immediate new DIVU 9/3 -> 3.
- Result ready with out_ready=0 for 5 cycles -> out_valid, out_result, out_tag held constant; in_ready=0; completes on first out_ready=1.
